// File: rtl/wb_commit_stage_if.sv
// MEM -> WB handshake and instruction payload for the writeback/commit stage.
// MEM drives the payload through the master modport; WB answers with ws_allowin.
interface wb_commit_stage_if;
   logic        ms_to_ws_valid;
   logic        ws_allowin;
   logic [31:0] ms_pc;
   logic [31:0] ms_result;
   logic [4:0]  ms_dest;
   logic        ms_gr_we;
   logic [31:0] ms_vaddr;
   logic [4:0]  ms_exc;        // {adef, ine, sys, brk, ale}
   logic        ms_ertn;
   logic        ms_csr_we;
   logic        ms_csr_re;
   logic [13:0] ms_csr_num;
   logic [31:0] ms_csr_wmask;
   logic [31:0] ms_csr_wvalue;
   logic [1:0]  ms_rdcnt;

   modport master (
      output ms_to_ws_valid, ms_pc, ms_result, ms_dest, ms_gr_we, ms_vaddr, ms_exc,
             ms_ertn, ms_csr_we, ms_csr_re, ms_csr_num, ms_csr_wmask, ms_csr_wvalue,
             ms_rdcnt,
      input  ws_allowin
   );

   modport slave (
      input  ms_to_ws_valid, ms_pc, ms_result, ms_dest, ms_gr_we, ms_vaddr, ms_exc,
             ms_ertn, ms_csr_we, ms_csr_re, ms_csr_num, ms_csr_wmask, ms_csr_wvalue,
             ms_rdcnt,
      output ws_allowin
   );
endinterface

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: latches one MEM instruction, resolves its exception,
// drives the CSR file and register-file write, raises the pipeline flush and owns the stable counter.
module wb_commit_stage #(
   parameter int          ECODE_W     = 6,
   // Counter value loaded on reset; nonzero only to reach the low-to-high word rollover quickly.
   parameter logic [63:0] CNT_RST_VAL = 64'h0
) (
   input  logic               clk,
   input  logic               reset,
   wb_commit_stage_if.slave   ms,
   input  logic               has_int,
   input  logic [31:0]        csr_rvalue,
   input  logic [31:0]        ex_entry,
   input  logic [31:0]        ex_epc,
   output logic               csr_we,
   output logic               csr_re,
   output logic [13:0]        csr_num,
   output logic [31:0]        csr_wmask,
   output logic [31:0]        csr_wvalue,
   output logic               wb_ex,
   output logic               ertn_flush,
   output logic [ECODE_W-1:0] wb_ecode,
   output logic [8:0]         wb_esubcode,
   output logic [31:0]        wb_pc,
   output logic [31:0]        wb_vaddr,
   output logic               flush,
   output logic [31:0]        flush_pc,
   output logic               rf_we,
   output logic [4:0]         rf_waddr,
   output logic [31:0]        rf_wdata
);

   localparam int CNT_W = 64;

   localparam int EXC_ADEF = 4;
   localparam int EXC_INE  = 3;
   localparam int EXC_SYS  = 2;
   localparam int EXC_BRK  = 1;
   localparam int EXC_ALE  = 0;

   localparam logic [ECODE_W-1:0] ECODE_INT  = ECODE_W'(6'h00);
   localparam logic [ECODE_W-1:0] ECODE_ADEF = ECODE_W'(6'h08);
   localparam logic [ECODE_W-1:0] ECODE_ALE  = ECODE_W'(6'h09);
   localparam logic [ECODE_W-1:0] ECODE_SYS  = ECODE_W'(6'h0B);
   localparam logic [ECODE_W-1:0] ECODE_BRK  = ECODE_W'(6'h0C);
   localparam logic [ECODE_W-1:0] ECODE_INE  = ECODE_W'(6'h0D);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] result;
      logic [31:0] vaddr;
      logic [4:0]  dest;
      logic        gr_we;
      logic [4:0]  exc;
      logic        ertn;
      logic        csr_we;
      logic        csr_re;
      logic [13:0] csr_num;
      logic [31:0] csr_wmask;
      logic [31:0] csr_wvalue;
      logic [1:0]  rdcnt;
   } ws_t;

   ws_t              ms_bus;
   ws_t              ws_q;
   logic             ws_valid;
   logic             ws_live;
   logic [CNT_W-1:0] cnt;

   assign ms_bus = '{
      pc:         ms.ms_pc,
      result:     ms.ms_result,
      vaddr:      ms.ms_vaddr,
      dest:       ms.ms_dest,
      gr_we:      ms.ms_gr_we,
      exc:        ms.ms_exc,
      ertn:       ms.ms_ertn,
      csr_we:     ms.ms_csr_we,
      csr_re:     ms.ms_csr_re,
      csr_num:    ms.ms_csr_num,
      csr_wmask:  ms.ms_csr_wmask,
      csr_wvalue: ms.ms_csr_wvalue,
      rdcnt:      ms.ms_rdcnt
   };

   // WB never stalls (ready_go is always 1), so it only refuses while reset is held.
   assign ms.ws_allowin = !reset;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         ws_valid <= 1'b0;
         // NOTE: the payload is reset too, so pass-through outputs read 0 rather than X after reset.
         ws_q     <= '0;
      end else begin
         if (flush) begin
            ws_valid <= 1'b0;
         end else if (ms.ws_allowin) begin
            ws_valid <= ms.ms_to_ws_valid;
         end
         if (ms.ws_allowin && ms.ms_to_ws_valid && !flush) begin
            ws_q <= ms_bus;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= CNT_RST_VAL;
      end else begin
         cnt <= cnt + 64'd1;
      end
   end

   // A held instruction must not commit anything while reset is asserted.
   assign ws_live = ws_valid && !reset;

   assign wb_ex       = ws_live && (has_int || (ws_q.exc != 5'b0));
   assign ertn_flush  = ws_live && ws_q.ertn && !wb_ex;
   assign flush       = wb_ex || ertn_flush;
   assign flush_pc    = reset ? 32'h0 : (wb_ex ? ex_entry : ex_epc);
   assign wb_esubcode = 9'h0;
   assign wb_pc       = reset ? 32'h0 : ws_q.pc;
   assign wb_vaddr    = reset ? 32'h0 : ws_q.vaddr;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      wb_ecode = ECODE_INT;
      if (ws_live) begin
         if (has_int)                  wb_ecode = ECODE_INT;
         else if (ws_q.exc[EXC_ADEF])  wb_ecode = ECODE_ADEF;
         else if (ws_q.exc[EXC_INE])   wb_ecode = ECODE_INE;
         else if (ws_q.exc[EXC_SYS])   wb_ecode = ECODE_SYS;
         else if (ws_q.exc[EXC_BRK])   wb_ecode = ECODE_BRK;
         else if (ws_q.exc[EXC_ALE])   wb_ecode = ECODE_ALE;
      end
   end

   assign csr_we     = ws_live && ws_q.csr_we && !wb_ex;
   assign csr_re     = ws_live && ws_q.csr_re && !wb_ex;
   assign csr_num    = reset ? 14'h0 : ws_q.csr_num;
   assign csr_wmask  = reset ? 32'h0 : ws_q.csr_wmask;
   assign csr_wvalue = reset ? 32'h0 : ws_q.csr_wvalue;

   assign rf_we    = ws_live && ws_q.gr_we && !wb_ex;
   assign rf_waddr = reset ? 5'h0 : ws_q.dest;

   // Counter reads see the value held during the WB cycle, before this edge's increment.
   always_comb begin
      rf_wdata = 32'h0;
      if (!reset) begin
         if (ws_q.rdcnt == 2'b01)      rf_wdata = cnt[31:0];
         else if (ws_q.rdcnt == 2'b10) rf_wdata = cnt[63:32];
         else if (ws_q.csr_re)         rf_wdata = csr_rvalue;
         else                          rf_wdata = ws_q.result;
      end
   end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Scoreboard bench for wb_commit_stage: each accepted instruction pushes its predicted
// WB-cycle outputs; a negedge monitor pops and compares them, and checks idle/reset cycles.
module tb_wb_commit_stage;

   localparam logic [63:0] CNT_INIT = 64'h0000_0000_FFFF_FFF0;

   typedef struct {
      logic [31:0] pc, result, vaddr;
      logic [4:0]  dest;
      logic        gr_we;
      logic [4:0]  exc;
      logic        ertn, csr_we, csr_re;
      logic [13:0] csr_num;
      logic [31:0] wmask, wvalue;
      logic [1:0]  rdcnt;
      logic        has_int;
      logic [31:0] csr_rvalue, ex_entry, ex_epc;
   } txn_t;

   typedef struct {
      int          due;
      logic        ex;
      logic [5:0]  ecode;
      logic        ertn_flush, flush;
      logic [31:0] flush_pc, pc, vaddr;
      logic        csr_we, csr_re;
      logic [13:0] csr_num;
      logic [31:0] wmask, wvalue;
      logic        rf_we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        has_int;
   logic [31:0] csr_rvalue, ex_entry, ex_epc;
   logic        csr_we, csr_re;
   logic [13:0] csr_num;
   logic [31:0] csr_wmask, csr_wvalue;
   logic        wb_ex, ertn_flush;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic [31:0] wb_pc, wb_vaddr;
   logic        flush;
   logic [31:0] flush_pc;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   wb_commit_stage_if ms_if ();

   wb_commit_stage #(.ECODE_W(6), .CNT_RST_VAL(CNT_INIT)) dut (
      .clk         (clk),
      .reset       (reset),
      .ms          (ms_if.slave),
      .has_int     (has_int),
      .csr_rvalue  (csr_rvalue),
      .ex_entry    (ex_entry),
      .ex_epc      (ex_epc),
      .csr_we      (csr_we),
      .csr_re      (csr_re),
      .csr_num     (csr_num),
      .csr_wmask   (csr_wmask),
      .csr_wvalue  (csr_wvalue),
      .wb_ex       (wb_ex),
      .ertn_flush  (ertn_flush),
      .wb_ecode    (wb_ecode),
      .wb_esubcode (wb_esubcode),
      .wb_pc       (wb_pc),
      .wb_vaddr    (wb_vaddr),
      .flush       (flush),
      .flush_pc    (flush_pc),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic [63:0] model_cnt = CNT_INIT;
   exp_t        sb[$];
   txn_t        pend;
   bit          pend_valid = 1'b0;

   always @(posedge clk) begin
      cyc++;
      model_cnt = reset ? CNT_INIT : model_cnt + 64'd1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic txn_t blank();
      txn_t t;
      t.pc = 32'h1c00_0000; t.result = 32'h0; t.vaddr = 32'h0; t.dest = 5'd1;
      t.gr_we = 1'b0; t.exc = 5'b0; t.ertn = 1'b0; t.csr_we = 1'b0; t.csr_re = 1'b0;
      t.csr_num = 14'h0; t.wmask = 32'h0; t.wvalue = 32'h0; t.rdcnt = 2'b00;
      t.has_int = 1'b0; t.csr_rvalue = 32'hC5C5_0000;
      t.ex_entry = 32'h1c00_8000; t.ex_epc = 32'h1c00_0100;
      return t;
   endfunction

   function automatic exp_t predict(txn_t t, logic [63:0] c, int due);
      exp_t e;
      e.due = due;
      e.ex  = t.has_int || (t.exc != 5'b0);
      if (t.has_int)     e.ecode = 6'h00;
      else if (t.exc[4]) e.ecode = 6'h08;
      else if (t.exc[3]) e.ecode = 6'h0D;
      else if (t.exc[2]) e.ecode = 6'h0B;
      else if (t.exc[1]) e.ecode = 6'h0C;
      else               e.ecode = 6'h09;
      e.ertn_flush = t.ertn && !e.ex;
      e.flush      = e.ex || e.ertn_flush;
      e.flush_pc   = e.ex ? t.ex_entry : t.ex_epc;
      e.pc = t.pc; e.vaddr = t.vaddr;
      e.csr_we = t.csr_we && !e.ex; e.csr_re = t.csr_re && !e.ex;
      e.csr_num = t.csr_num; e.wmask = t.wmask; e.wvalue = t.wvalue;
      e.rf_we = t.gr_we && !e.ex; e.waddr = t.dest;
      if (t.rdcnt == 2'b01)      e.wdata = c[31:0];
      else if (t.rdcnt == 2'b10) e.wdata = c[63:32];
      else if (t.csr_re)         e.wdata = t.csr_rvalue;
      else                       e.wdata = t.result;
      return e;
   endfunction

   // One negedge: apply WB-side inputs for the instruction now in WB, offer the next one.
   task automatic drive_cycle(input bit valid, input txn_t t);
      bit flush_now;
      @(negedge clk);
      if (pend_valid) begin
         has_int = pend.has_int; csr_rvalue = pend.csr_rvalue;
         ex_entry = pend.ex_entry; ex_epc = pend.ex_epc;
      end else begin
         has_int = 1'($urandom_range(0, 1)); csr_rvalue = $urandom;
         ex_entry = $urandom; ex_epc = $urandom;
      end
      flush_now = pend_valid && (pend.has_int || (pend.exc != 5'b0) || pend.ertn);
      ms_if.ms_to_ws_valid = valid;
      ms_if.ms_pc = t.pc; ms_if.ms_result = t.result; ms_if.ms_vaddr = t.vaddr;
      ms_if.ms_dest = t.dest; ms_if.ms_gr_we = t.gr_we; ms_if.ms_exc = t.exc;
      ms_if.ms_ertn = t.ertn; ms_if.ms_csr_we = t.csr_we; ms_if.ms_csr_re = t.csr_re;
      ms_if.ms_csr_num = t.csr_num; ms_if.ms_csr_wmask = t.wmask;
      ms_if.ms_csr_wvalue = t.wvalue; ms_if.ms_rdcnt = t.rdcnt;
      if (valid && !flush_now) begin
         sb.push_back(predict(t, model_cnt + 64'd1, cyc + 1));
         pend = t;
         pend_valid = 1'b1;
      end else begin
         pend_valid = 1'b0;
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b1;
      has_int = 1'b1;
      ms_if.ms_to_ws_valid = 1'b0;
      sb.delete();
      pend_valid = 1'b0;
      repeat (n - 1) @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      #2;
      if (reset) begin
         check("rst_allowin", ms_if.ws_allowin, 0);
         check("rst_wb_ex", wb_ex, 0);
         check("rst_ertn_flush", ertn_flush, 0);
         check("rst_flush", flush, 0);
         check("rst_flush_pc", flush_pc, 0);
         check("rst_rf_we", rf_we, 0);
         check("rst_rf_wdata", rf_wdata, 0);
         check("rst_csr_we", csr_we, 0);
         check("rst_csr_re", csr_re, 0);
         check("rst_wb_pc", wb_pc, 0);
      end else begin
         check("allowin", ms_if.ws_allowin, 1);
         if (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check("due_cycle", cyc, e.due);
            check("wb_ex", wb_ex, e.ex);
            if (e.ex) begin
               check("ecode", wb_ecode, e.ecode);
               check("esubcode", wb_esubcode, 0);
            end
            check("ertn_flush", ertn_flush, e.ertn_flush);
            check("flush", flush, e.flush);
            if (e.flush) check("flush_pc", flush_pc, e.flush_pc);
            check("wb_pc", wb_pc, e.pc);
            check("wb_vaddr", wb_vaddr, e.vaddr);
            check("csr_we", csr_we, e.csr_we);
            check("csr_re", csr_re, e.csr_re);
            if (e.csr_we || e.csr_re) begin
               check("csr_num", csr_num, e.csr_num);
               check("csr_wmask", csr_wmask, e.wmask);
               check("csr_wvalue", csr_wvalue, e.wvalue);
            end
            check("rf_we", rf_we, e.rf_we);
            if (e.rf_we) begin
               check("rf_waddr", rf_waddr, e.waddr);
               check("rf_wdata", rf_wdata, e.wdata);
            end
         end else begin
            check("idle_wb_ex", wb_ex, 0);
            check("idle_ertn_flush", ertn_flush, 0);
            check("idle_flush", flush, 0);
            check("idle_rf_we", rf_we, 0);
            check("idle_csr_we", csr_we, 0);
            check("idle_csr_re", csr_re, 0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      txn_t t;
      has_int = 1'b0; csr_rvalue = 32'h0; ex_entry = 32'h0; ex_epc = 32'h0;
      t = blank();
      ms_if.ms_to_ws_valid = 1'b0;
      ms_if.ms_pc = 32'h0; ms_if.ms_result = 32'h0; ms_if.ms_vaddr = 32'h0;
      ms_if.ms_dest = 5'h0; ms_if.ms_gr_we = 1'b0; ms_if.ms_exc = 5'h0;
      ms_if.ms_ertn = 1'b0; ms_if.ms_csr_we = 1'b0; ms_if.ms_csr_re = 1'b0;
      ms_if.ms_csr_num = 14'h0; ms_if.ms_csr_wmask = 32'h0;
      ms_if.ms_csr_wvalue = 32'h0; ms_if.ms_rdcnt = 2'b00;
      do_reset(3);

      // Counter reads straddling the 32-bit rollover of the stable counter.
      for (int i = 0; i < 64 && model_cnt != 64'hFFFF_FFFC; i++) drive_cycle(1'b0, blank());
      for (int i = 0; i < 5; i++) begin
         t = blank(); t.gr_we = 1'b1; t.dest = 5'(7 + i);
         t.rdcnt = (i % 2 == 0) ? 2'b01 : 2'b10;
         drive_cycle(1'b1, t);
      end
      drive_cycle(1'b0, blank());

      // Plain ALU write.
      t = blank(); t.pc = 32'h1c00_0000; t.dest = 5'd5; t.result = 32'h1234; t.gr_we = 1'b1;
      drive_cycle(1'b1, t);
      // syscall, then an instruction offered during its flush, then one right after.
      t = blank(); t.pc = 32'h1c00_0010; t.exc = 5'b00100; t.gr_we = 1'b1; t.csr_we = 1'b1;
      t.ex_entry = 32'h1c00_8000;
      drive_cycle(1'b1, t);
      t = blank(); t.pc = 32'h1c00_0014; t.gr_we = 1'b1; t.dest = 5'd9; t.csr_we = 1'b1;
      drive_cycle(1'b1, t);
      t = blank(); t.pc = 32'h1c00_0018; t.gr_we = 1'b1; t.dest = 5'd10; t.result = 32'h55;
      drive_cycle(1'b1, t);

      // Priority: interrupt over adef+ale, then adef over ale.
      t = blank(); t.exc = 5'b10001; t.has_int = 1'b1; t.vaddr = 32'h0000_0003;
      drive_cycle(1'b1, t);
      drive_cycle(1'b0, blank());
      t.has_int = 1'b0;
      drive_cycle(1'b1, t);
      drive_cycle(1'b0, blank());

      // ertn with and without a pending interrupt.
      t = blank(); t.ertn = 1'b1; t.has_int = 1'b1; t.ex_entry = 32'h1c00_9000;
      drive_cycle(1'b1, t);
      drive_cycle(1'b0, blank());
      t.has_int = 1'b0; t.ex_epc = 32'h1c00_0444;
      drive_cycle(1'b1, t);
      drive_cycle(1'b0, blank());

      // Remaining exception codes and priorities.
      for (int i = 0; i < 5; i++) begin
         t = blank(); t.gr_we = 1'b1; t.pc = 32'h1c00_0200 + 32'(i * 4);
         case (i)
            0: t.exc = 5'b01000;
            1: t.exc = 5'b00010;
            2: t.exc = 5'b00001;
            3: t.exc = 5'b00011;
            default: t.exc = 5'b00110;
         endcase
         drive_cycle(1'b1, t);
         drive_cycle(1'b0, blank());
      end

      // csrxchg (write+read) and csrrd, back to back.
      t = blank(); t.gr_we = 1'b1; t.dest = 5'd12; t.csr_we = 1'b1; t.csr_re = 1'b1;
      t.csr_num = 14'h0006; t.wmask = 32'h0000_FFFF; t.wvalue = 32'hABCD_1234;
      t.csr_rvalue = 32'h7777_8888; t.result = 32'hDEAD_BEEF;
      drive_cycle(1'b1, t);
      t = blank(); t.gr_we = 1'b1; t.dest = 5'd13; t.csr_re = 1'b1;
      t.csr_num = 14'h0040; t.csr_rvalue = 32'h1357_9BDF;
      drive_cycle(1'b1, t);

      // Random mixed traffic.
      for (int i = 0; i < 80; i++) begin
         t = blank();
         t.pc = $urandom; t.result = $urandom; t.vaddr = $urandom; t.dest = 5'($urandom);
         t.gr_we = 1'($urandom); t.csr_we = ($urandom_range(0, 3) == 0);
         t.csr_re = ($urandom_range(0, 3) == 0); t.csr_num = 14'($urandom);
         t.wmask = $urandom; t.wvalue = $urandom; t.csr_rvalue = $urandom;
         t.rdcnt = 2'($urandom_range(0, 2)); t.ertn = ($urandom_range(0, 7) == 0);
         t.exc = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
         t.has_int = ($urandom_range(0, 7) == 0);
         t.ex_entry = $urandom; t.ex_epc = $urandom;
         drive_cycle($urandom_range(0, 4) != 0, t);
      end
      drive_cycle(1'b0, blank());

      // Reset while an interrupted syscall sits in WB: nothing may commit.
      t = blank(); t.exc = 5'b00100; t.has_int = 1'b1; t.gr_we = 1'b1;
      drive_cycle(1'b1, t);
      do_reset(2);
      t = blank(); t.pc = 32'h1c00_0300; t.dest = 5'd3; t.result = 32'hCAFE; t.gr_we = 1'b1;
      drive_cycle(1'b1, t);
      drive_cycle(1'b0, blank());
      drive_cycle(1'b0, blank());

      @(negedge clk);
      #3;
      check("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
